instr_exec_register: RTL

Parametrised successor to the single-cycle instruction register. It stores up to DEPTH instruction entries (opcode, two signed operands, result) and computes each result on load. ADD/SUB/MULT/PASS/ZERO complete in the load cycle. DIV/MOD/POW run on an iterative engine with a busy/done handshake. It sits between the instruction stimulus source and any consumer that reads entries back by address.

---
 rtl/instr_register_pkg.sv | 26 ++
 rtl/instr_iter_unit.sv | 121 ++++++++++++
 rtl/instr_exec_register.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// instr_register_pkg: opcode encoding, iterative engine states and default sizes
// shared by instr_exec_register and instr_iter_unit.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } eng_state_t;

  localparam int OP_WIDTH_DEF = 32;
  localparam int DEPTH_DEF    = 32;

endpackage

// File: rtl/instr_iter_unit.sv
// instr_iter_unit: iterative DIV/MOD/POW engine with a fixed OP_WIDTH-cycle run
// phase followed by one write-back cycle. Optional macro INSTR_REG_ERR_FLAGS_EN
// adds a fault output (divide-by-zero or negative exponent).
module instr_iter_unit
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  opcode_t               opc,
  input  logic [OP_WIDTH-1:0]   a,
  input  logic [OP_WIDTH-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic                  wb,
  output logic [2*OP_WIDTH-1:0] result
`ifdef INSTR_REG_ERR_FLAGS_EN
  ,
  output logic                  fault
`endif
);
  localparam int W  = OP_WIDTH;
  localparam int CW = $clog2(W);

  eng_state_t     state;
  logic [CW-1:0]  cnt;
  opcode_t        opc_r;
  logic [W-1:0]   rem, quo, dvs, ex;
  logic [2*W-1:0] acc, base;
  logic           neg_q, neg_r, zero_r;
  logic [W:0]     rem_sh, q_s, r_s;
  logic [W-1:0]   rem_sub;
  logic           ge;

  assign busy = (state != ST_IDLE);
  assign wb   = (state == ST_WRITE);
`ifdef INSTR_REG_ERR_FLAGS_EN
  assign fault = zero_r;
`endif

  // One restoring-division step: shift the next dividend bit into the partial remainder
  always_comb begin
    rem_sh  = {rem, quo[W-1]};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_sub = rem_sh[W-1:0] - dvs;
  end

  // Sign-correct the magnitudes and select the final result presented during WRITE
  always_comb begin
    q_s    = neg_q ? -{1'b0, quo} : {1'b0, quo};
    r_s    = neg_r ? -{1'b0, rem} : {1'b0, rem};
    result = '0;
    if (!zero_r) begin
      case (opc_r)
        DIV:     result = {{(W-1){q_s[W]}}, q_s};
        MOD:     result = {{(W-1){r_s[W]}}, r_s};
        POW:     result = acc;
        default: result = '0;
      endcase
    end
  end

  // Engine FSM and datapath: latch operands on start, iterate W steps, then write back
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      opc_r  <= ZERO;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      ex     <= '0;
      acc    <= '0;
      base   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            cnt    <= '0;
            opc_r  <= opc;
            rem    <= '0;
            quo    <= a[W-1] ? -a : a;
            dvs    <= b[W-1] ? -b : b;
            neg_q  <= a[W-1] ^ b[W-1];
            neg_r  <= a[W-1];
            ex     <= b;
            acc    <= (2*W)'(1);
            base   <= {{W{a[W-1]}}, a};
            zero_r <= (opc == POW) ? b[W-1] : (b == '0);
          end
        end
        ST_RUN: begin
          if (opc_r == POW) begin
            if (ex[0]) acc <= acc * base;
            base <= base * base;
            ex   <= ex >> 1;
          end else begin
            rem <= ge ? rem_sub : rem_sh[W-1:0];
            quo <= {quo[W-2:0], ge};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/instr_exec_register.sv
// instr_exec_register: DEPTH-entry instruction store that computes each entry's
// result on load; single-cycle ops inline, DIV/MOD/POW through instr_iter_unit.
// Optional macro INSTR_REG_ERR_FLAGS_EN adds a per-entry err bit and the err port.
module instr_exec_register
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
`ifdef INSTR_REG_ERR_FLAGS_EN
  localparam int IW = 4*OP_WIDTH + 5
`else
  localparam int IW = 4*OP_WIDTH + 4
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  opcode_t             opcode,
  input  logic [OP_WIDTH-1:0] operand_a,
  input  logic [OP_WIDTH-1:0] operand_b,
  input  logic [AW-1:0]       write_pointer,
  input  logic [AW-1:0]       read_pointer,
  output logic [IW-1:0]       instruction_word,
  output logic                busy,
  output logic                done
`ifdef INSTR_REG_ERR_FLAGS_EN
  ,
  output logic                err
`endif
);
  localparam int W = OP_WIDTH;

  typedef struct packed {
    opcode_t        opc;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] result;
`ifdef INSTR_REG_ERR_FLAGS_EN
    logic           err;
`endif
  } instruction_t;

  instruction_t   mem [DEPTH];
  instruction_t   rd_q, new_ent;
  logic           accept, is_iter, start;
  logic           it_busy, it_done, it_wb;
  logic [2*W-1:0] sa, sb, sc_res, it_result;
  logic [AW-1:0]  pend_idx;
`ifdef INSTR_REG_ERR_FLAGS_EN
  logic           ld_fault, it_fault, fault_q, drop_q;
`endif

  assign busy             = it_busy;
  assign done             = it_done;
  assign instruction_word = rd_q;
  assign accept  = load_en && !it_busy && (int'(write_pointer) < DEPTH);
  assign is_iter = opcode inside {DIV, MOD, POW};
  assign start   = accept && is_iter;

  // Single-cycle result and the entry image written at an accepted load
  always_comb begin
    sa     = {{W{operand_a[W-1]}}, operand_a};
    sb     = {{W{operand_b[W-1]}}, operand_b};
    sc_res = '0;
    case (opcode)
      PASSA:   sc_res = sa;
      PASSB:   sc_res = sb;
      ADD:     sc_res = sa + sb;
      SUB:     sc_res = sa - sb;
      MULT:    sc_res = sa * sb;
      default: sc_res = '0;
    endcase
    new_ent        = '0;
    new_ent.opc    = opcode;
    new_ent.a      = operand_a;
    new_ent.b      = operand_b;
    new_ent.result = is_iter ? '0 : sc_res;
`ifdef INSTR_REG_ERR_FLAGS_EN
    ld_fault = ((opcode == DIV || opcode == MOD) && operand_b == '0) ||
               (opcode == POW && operand_b[W-1]) || (opcode > POW);
    new_ent.err = ld_fault;
`endif
  end

  instr_iter_unit #(.OP_WIDTH(W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opc    (opcode),
    .a      (operand_a),
    .b      (operand_b),
    .busy   (it_busy),
    .done   (it_done),
    .wb     (it_wb),
    .result (it_result)
`ifdef INSTR_REG_ERR_FLAGS_EN
    ,
    .fault  (it_fault)
`endif
  );

  // Storage, registered read (read-before-write) and iterative write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_q     <= '0;
      pend_idx <= '0;
    end else begin
      rd_q <= (int'(read_pointer) < DEPTH) ? mem[read_pointer] : '0;
      if (accept) mem[write_pointer] <= new_ent;
      if (start) pend_idx <= write_pointer;
      if (it_wb) begin
        mem[pend_idx].result <= it_result;
`ifdef INSTR_REG_ERR_FLAGS_EN
        mem[pend_idx].err <= it_fault;
`endif
      end
    end
  end

`ifdef INSTR_REG_ERR_FLAGS_EN
  // err holds the last accepted load's fault, with a one-cycle pulse for a dropped load
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= load_en && !accept;
      if (accept) fault_q <= ld_fault;
    end
  end
  assign err = fault_q | drop_q;
`endif

endmodule
